// File: rtl/switch_config_loader.sv
// Serial configuration loader: shifts LSB-first select fields into a register
// and strobes them one-hot into NUM_MUX switch muxes, one mux per field.
module switch_config_loader #(
  parameter  int NUM_MUX = 8,
  parameter  int INPUTS  = 4,
  localparam int SEL_W   = $clog2(INPUTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_ready,
  output logic [SEL_W-1:0]   mux_sel,
  output logic [NUM_MUX-1:0] mux_enable,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int BIT_W = (SEL_W > 1) ? $clog2(SEL_W) : 1;
  localparam int IDX_W = (NUM_MUX > 1) ? $clog2(NUM_MUX) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SEL_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_MUX - 1);
  localparam logic [SEL_W:0]   RANGE_LIM = (SEL_W + 1)'(INPUTS);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] shift_reg;
  logic             accept;
  logic             field_end;
  logic             in_range;
  logic [SEL_W-1:0] field;

  assign accept    = (state == SHIFT) && cfg_valid;
  assign field_end = accept && (bit_cnt == BIT_LAST);
  // The incoming bit is merged at its own position so the completed field is
  // available in the same cycle as the final accepted bit.
  assign field     = shift_reg | (SEL_W'(cfg_bit) << bit_cnt);
  assign in_range  = {1'b0, field} < RANGE_LIM;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (field_end) state_next = WRITE;
      WRITE:   state_next = (idx == IDX_LAST) ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == SHIFT);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Select and strobe are loaded together on the last bit so both are
  // registered and valid for the whole WRITE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt    <= '0;
      idx        <= '0;
      shift_reg  <= '0;
      mux_sel    <= '0;
      mux_enable <= '0;
      cfg_err    <= 1'b0;
    end else begin
      mux_enable <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt   <= '0;
            idx       <= '0;
            shift_reg <= '0;
            cfg_err   <= 1'b0;
          end
        end
        SHIFT: begin
          if (field_end) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            mux_sel   <= field;
            if (in_range) begin
              mux_enable <= NUM_MUX'(1) << idx;
            end else begin
              cfg_err <= 1'b1;
            end
          end else if (accept) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= field;
          end
        end
        WRITE: begin
          if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_config_loader.sv
// Bench for switch_config_loader: randomized and directed frames on a
// 4-mux/3-input loader with a strobe scoreboard, plus a 1-mux/2-input instance.
module tb_switch_config_loader;

  localparam int N   = 4;
  localparam int INP = 3;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic          cfg_ready, busy, done, cfg_err;
  logic [SW-1:0] mux_sel;
  logic [N-1:0]  mux_enable;

  logic          b_start = 1'b0, b_cfg_valid = 1'b0, b_cfg_bit = 1'b0;
  logic          b_cfg_ready, b_busy, b_done, b_cfg_err;
  logic [0:0]    b_mux_sel;
  logic [0:0]    b_mux_enable;

  switch_config_loader #(.NUM_MUX(N), .INPUTS(INP)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .mux_sel(mux_sel),
    .mux_enable(mux_enable), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  switch_config_loader #(.NUM_MUX(1), .INPUTS(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .cfg_valid(b_cfg_valid),
    .cfg_bit(b_cfg_bit), .cfg_ready(b_cfg_ready), .mux_sel(b_mux_sel),
    .mux_enable(b_mux_enable), .busy(b_busy), .done(b_done), .cfg_err(b_cfg_err)
  );

  typedef struct {
    bit            is_done;
    logic [N-1:0]  en;
    logic [SW-1:0] sel;
    bit            err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Scoreboard monitor: every observed strobe or done must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (mux_enable != '0) begin
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        fail_now("unexpected_strobe");
      end else begin
        e = exp_q.pop_front();
        check_output("strobe_en", 32'(mux_enable), 32'(e.en));
        check_output("strobe_sel", 32'(mux_sel), 32'(e.sel));
      end
    end
    if (done) begin
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        fail_now("unexpected_done");
      end else begin
        e = exp_q.pop_front();
        check_output("done_err", 32'(cfg_err), 32'(e.err));
      end
    end
  end

  task automatic send_bit(input logic b, input int idle, input bit chk_ready);
    int w;
    repeat (idle) begin
      cfg_valid = 1'b0;
      if (chk_ready) check_output("stall_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    w = 0;
    while (!cfg_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) fail_now("ready_timeout");
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Issues one frame; expected strobes come straight from the field values.
  task automatic apply_stimulus(input logic [SW-1:0] f[N], input int stall_at, input int stall_len,
                                input int start_at, input int abort_at, input bit rand_idle,
                                input bit check_len);
    bit   err;
    int   c0, w, idle, nbits;
    exp_t e;
    err = 0;
    nbits = (abort_at >= 0) ? abort_at : N * SW;
    for (int i = 0; i < N; i++) begin
      if (f[i] >= INP) begin
        err = 1;
      end else if ((i + 1) * SW <= nbits) begin
        e.is_done = 0; e.en = N'(1) << i; e.sel = f[i]; e.err = 0;
        exp_q.push_back(e);
      end
    end
    if (abort_at < 0) begin
      e.is_done = 1; e.en = '0; e.sel = '0; e.err = err;
      exp_q.push_back(e);
    end
    c0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_clears_err", 32'(cfg_err), 32'd0);
    for (int k = 0; k < nbits; k++) begin
      if (k == start_at) start = 1'b1;
      idle = (k == stall_at) ? stall_len : (rand_idle ? int'($urandom_range(0, 2)) : 0);
      send_bit(f[k / SW][k % SW], idle, k == stall_at);
      start = 1'b0;
    end
    if (abort_at >= 0) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_output("abort_ready", 32'(cfg_ready), 32'd0);
      check_output("abort_en", 32'(mux_enable), 32'd0);
      check_output("abort_sel", 32'(mux_sel), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(done), 32'd0);
      check_output("abort_err", 32'(cfg_err), 32'd0);
      repeat (4) @(negedge clk);
      check_output("abort_stays_idle", 32'(busy), 32'd0);
    end else begin
      w = 0;
      while (!done && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) fail_now("done_timeout");
      else if (check_len) check_output("frame_len", 32'(cyc - c0), 32'(N * (SW + 1) + 1 + stall_len));
      @(negedge clk);
      check_output("err_hold_idle", 32'(cfg_err), 32'(err));
      check_output("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [SW-1:0] fr[N];
    repeat (3) @(negedge clk);
    check_output("rst_ready", 32'(cfg_ready), 32'd0);
    check_output("rst_sel", 32'(mux_sel), 32'd0);
    check_output("rst_en", 32'(mux_enable), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(cfg_err), 32'd0);
    check_output("rst_b_en", 32'(b_mux_enable), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    fr = '{2'd1, 2'd2, 2'd0, 2'd2};
    apply_stimulus(fr, -1, 0, -1, -1, 0, 1);
    apply_stimulus(fr, 3, 5, -1, -1, 0, 1);
    fr = '{2'd1, 2'd3, 2'd0, 2'd2};
    apply_stimulus(fr, -1, 0, -1, -1, 0, 1);
    fr = '{2'd2, 2'd1, 2'd0, 2'd1};
    apply_stimulus(fr, -1, 0, 5, -1, 0, 1);
    fr = '{2'd1, 2'd2, 2'd1, 2'd0};
    apply_stimulus(fr, -1, 0, -1, 5, 0, 0);
    fr = '{2'd0, 2'd1, 2'd2, 2'd1};
    apply_stimulus(fr, -1, 0, -1, -1, 0, 1);
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) fr[i] = SW'($urandom_range(0, 3));
      apply_stimulus(fr, -1, 0, -1, -1, 1, 0);
    end

    // Single-mux instance: one bit per frame.
    for (int v = 1; v >= 0; v--) begin
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      b_cfg_valid = 1'b1;
      b_cfg_bit = v[0];
      @(negedge clk);
      b_cfg_valid = 1'b0;
      check_output("b_write_en", 32'(b_mux_enable), 32'd1);
      check_output("b_write_sel", 32'(b_mux_sel), 32'(v));
      @(negedge clk);
      check_output("b_done", 32'(b_done), 32'd1);
      check_output("b_err", 32'(b_cfg_err), 32'd0);
      @(negedge clk);
      check_output("b_idle_busy", 32'(b_busy), 32'd0);
      check_output("b_idle_en", 32'(b_mux_enable), 32'd0);
    end

    repeat (3) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
